// File: rtl/mc_pkg.sv
// Shared constants and types for the MIPS-lite multicycle controller.
package mc_pkg;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEMACC = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_HALT   = 4'd8
    } state_e;

    typedef enum logic [3:0] {
        CLS_RTYPE,
        CLS_ORI,
        CLS_LUI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_J,
        CLS_JAL,
        CLS_ILL
    } iclass_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_OR    = 3'd2;
    localparam logic [2:0] ALU_LUI   = 3'd3;
    localparam logic [2:0] ALU_FUNCT = 3'd4;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_SEXT = 2'd2;
    localparam logic [1:0] SRCB_ZEXT = 2'd3;

    localparam int unsigned WAIT_W = 8;

    // States that own the memory port and are subject to the timeout.
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMACC);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Opcode/funct classifier for mc_ctrl; jal is legal only with MC_CTRL_JAL_EN.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output iclass_e    cls_o,
    output logic       illegal_o
);

    always_comb begin
        cls_o = CLS_ILL;
        case (opcode_i)
            OP_RTYPE: begin
                if ((funct_i == FN_ADDU) || (funct_i == FN_SUBU)) begin
                    cls_o = CLS_RTYPE;
                end
            end
            OP_ORI: cls_o = CLS_ORI;
            OP_LUI: cls_o = CLS_LUI;
            OP_LW:  cls_o = CLS_LW;
            OP_SW:  cls_o = CLS_SW;
            OP_BEQ: cls_o = CLS_BEQ;
            OP_J:   cls_o = CLS_J;
`ifdef MC_CTRL_JAL_EN
            OP_JAL: cls_o = CLS_JAL;
`else
            OP_JAL: cls_o = CLS_ILL;
`endif
            default: cls_o = CLS_ILL;
        endcase
        illegal_o = (cls_o == CLS_ILL);
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM for the MIPS-lite core with retire counter and memory timeout.
// Optional jal support (link write to $31) is enabled by defining MC_CTRL_JAL_EN.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             gpr_write_enable,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             halted,
    output logic             bus_fault,
    output logic             link_sel,
    output logic [CNT_W-1:0] retired
);

    // Last wait count before the next missed mem_ready becomes a fault.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               bus_fault_q, bus_fault_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               retire_c;
    logic               timeout_c;
    iclass_e            cls;
    logic               illegal;

    mc_decode u_decode (
        .opcode_i  (opcode),
        .funct_i   (funct),
        .cls_o     (cls),
        .illegal_o (illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RST;
            wait_q      <= '0;
            bus_fault_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            bus_fault_q <= bus_fault_d;
            retired_q   <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        retire_c  = 1'b0;
        timeout_c = is_mem_state(state_q) && !mem_ready && (wait_q == WAIT_LAST);
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_c) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                if (illegal) begin
                    state_d = S_HALT;
                end else begin
                    case (cls)
                        CLS_BEQ:        state_d = S_BRANCH;
                        CLS_J, CLS_JAL: state_d = S_JUMP;
                        default:        state_d = S_EXEC;
                    endcase
                end
            end
            S_EXEC: begin
                state_d = ((cls == CLS_LW) || (cls == CLS_SW)) ? S_MEMACC : S_WB;
            end
            S_MEMACC: begin
                if (mem_ready) begin
                    if (cls == CLS_SW) begin
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d  = S_WB;
                    end
                end else if (timeout_c) begin
                    state_d = S_HALT;
                end
            end
            S_WB, S_BRANCH, S_JUMP: begin
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase

        // Wait counter restarts whenever a memory-owning state is freshly entered.
        if (is_mem_state(state_d) && (state_d != state_q)) begin
            wait_d = '0;
        end else if (is_mem_state(state_q) && !mem_ready) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = wait_q;
        end

        bus_fault_d = bus_fault_q | timeout_c;
        retired_d   = retire_c ? (retired_q + CNT_W'(1)) : retired_q;
    end

    always_comb begin
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        iord             = 1'b0;
        ir_write         = 1'b0;
        pc_write         = 1'b0;
        pc_src           = PC_SEQ;
        alu_src_a        = 1'b0;
        alu_src_b        = SRCB_RT;
        alu_op           = ALU_ADD;
        gpr_write_enable = 1'b0;
        reg_dst          = 1'b0;
        mem_to_reg       = 1'b0;
        halted           = 1'b0;
        link_sel         = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                pc_src    = PC_SEQ;
            end
            S_DECODE: begin
                alu_src_b = SRCB_SEXT;
                alu_op    = ALU_ADD;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (cls)
                    CLS_RTYPE: begin
                        alu_src_b = SRCB_RT;
                        alu_op    = ALU_FUNCT;
                    end
                    CLS_ORI: begin
                        alu_src_b = SRCB_ZEXT;
                        alu_op    = ALU_OR;
                    end
                    CLS_LUI: begin
                        alu_src_b = SRCB_ZEXT;
                        alu_op    = ALU_LUI;
                    end
                    default: begin
                        alu_src_b = SRCB_SEXT;
                        alu_op    = ALU_ADD;
                    end
                endcase
            end
            S_MEMACC: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (cls == CLS_SW);
            end
            S_WB: begin
                gpr_write_enable = 1'b1;
                reg_dst          = (cls == CLS_RTYPE);
                mem_to_reg       = (cls == CLS_LW);
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RT;
                alu_op    = ALU_SUB;
                pc_write  = alu_zero;
                pc_src    = PC_BRANCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
`ifdef MC_CTRL_JAL_EN
                if (cls == CLS_JAL) begin
                    gpr_write_enable = 1'b1;
                    link_sel         = 1'b1;
                end
`endif
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign bus_fault = bus_fault_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed, table-driven bench for mc_ctrl (MEM_TIMEOUT = 4), plus a 2-bit-counter copy for wrap checks.
module tb_mc_ctrl;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        zero;
        logic        rdy;
        logic [18:0] ctl;
        logic [31:0] ret;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        alu_zero;
    logic        mem_ready;
    wire  [18:0] a_ctl;
    wire  [18:0] b_ctl;
    wire  [31:0] retired;
    wire  [1:0]  retired_w;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t q[$];

    always #5 clk = ~clk;

    mc_ctrl #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(a_ctl[18]), .mem_we(a_ctl[17]), .iord(a_ctl[16]),
        .ir_write(a_ctl[15]), .pc_write(a_ctl[14]), .pc_src(a_ctl[13:12]),
        .alu_src_a(a_ctl[11]), .alu_src_b(a_ctl[10:9]), .alu_op(a_ctl[8:6]),
        .gpr_write_enable(a_ctl[5]), .reg_dst(a_ctl[4]), .mem_to_reg(a_ctl[3]),
        .halted(a_ctl[2]), .bus_fault(a_ctl[1]), .link_sel(a_ctl[0]),
        .retired(retired)
    );

    mc_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_w (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(b_ctl[18]), .mem_we(b_ctl[17]), .iord(b_ctl[16]),
        .ir_write(b_ctl[15]), .pc_write(b_ctl[14]), .pc_src(b_ctl[13:12]),
        .alu_src_a(b_ctl[11]), .alu_src_b(b_ctl[10:9]), .alu_op(b_ctl[8:6]),
        .gpr_write_enable(b_ctl[5]), .reg_dst(b_ctl[4]), .mem_to_reg(b_ctl[3]),
        .halted(b_ctl[2]), .bus_fault(b_ctl[1]), .link_sel(b_ctl[0]),
        .retired(retired_w)
    );

    // Packs expected outputs in the same bit order as a_ctl (link_sel defaults to 0).
    function automatic logic [18:0] mk(input bit req, we, io, irw, pcw, input bit [1:0] pcs,
                                       input bit sa, input bit [1:0] sb, input bit [2:0] aop,
                                       input bit gwe, rd, m2r, h, bf);
        return {req, we, io, irw, pcw, pcs, sa, sb, aop, gwe, rd, m2r, h, bf, 1'b0};
    endfunction

    task automatic add(input bit r, input bit [5:0] op, input bit [5:0] fn, input bit z,
                       input bit rdy, input logic [18:0] c, input int unsigned ret);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.zero = z; v.rdy = rdy; v.ctl = c; v.ret = ret;
        q.push_back(v);
    endtask

    task automatic check(input string tag, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] actual=%0h expected=%0h", tag, idx, act, exp);
        end
    endtask

    // One vector per cycle: drive at negedge, sample 1 ns later, before the next rising edge.
    task automatic run(input string tag);
        foreach (q[i]) begin
            @(negedge clk);
            rst = q[i].rst; opcode = q[i].op; funct = q[i].fn;
            alu_zero = q[i].zero; mem_ready = q[i].rdy;
            #1;
            check({tag, ".ctl"}, i, 32'(a_ctl), 32'(q[i].ctl));
            check({tag, ".ret"}, i, retired, q[i].ret);
            check({tag, ".ctl_w"}, i, 32'(b_ctl), 32'(q[i].ctl));
            check({tag, ".ret_w"}, i, 32'(retired_w), 32'(q[i].ret[1:0]));
        end
        q.delete();
    endtask

    logic [18:0] cZ, cF0, cF1, cD, cER, cEO, cEL, cEM, cML, cMS;
    logic [18:0] cWR, cWI, cWL, cB1, cB0, cJ, cH, cHB, cJL;

    initial begin
        rst = 1'b0; opcode = 6'h00; funct = 6'h00; alu_zero = 1'b0; mem_ready = 1'b1;

        cZ  = '0;
        cF0 = mk(1,0,0,0,0,2'd0,0,2'd1,3'd0,0,0,0,0,0);
        cF1 = mk(1,0,0,1,1,2'd0,0,2'd1,3'd0,0,0,0,0,0);
        cD  = mk(0,0,0,0,0,2'd0,0,2'd2,3'd0,0,0,0,0,0);
        cER = mk(0,0,0,0,0,2'd0,1,2'd0,3'd4,0,0,0,0,0);
        cEO = mk(0,0,0,0,0,2'd0,1,2'd3,3'd2,0,0,0,0,0);
        cEL = mk(0,0,0,0,0,2'd0,1,2'd3,3'd3,0,0,0,0,0);
        cEM = mk(0,0,0,0,0,2'd0,1,2'd2,3'd0,0,0,0,0,0);
        cML = mk(1,0,1,0,0,2'd0,0,2'd0,3'd0,0,0,0,0,0);
        cMS = mk(1,1,1,0,0,2'd0,0,2'd0,3'd0,0,0,0,0,0);
        cWR = mk(0,0,0,0,0,2'd0,0,2'd0,3'd0,1,1,0,0,0);
        cWI = mk(0,0,0,0,0,2'd0,0,2'd0,3'd0,1,0,0,0,0);
        cWL = mk(0,0,0,0,0,2'd0,0,2'd0,3'd0,1,0,1,0,0);
        cB1 = mk(0,0,0,0,1,2'd1,1,2'd0,3'd1,0,0,0,0,0);
        cB0 = mk(0,0,0,0,0,2'd1,1,2'd0,3'd1,0,0,0,0,0);
        cJ  = mk(0,0,0,0,1,2'd2,0,2'd0,3'd0,0,0,0,0,0);
        cH  = mk(0,0,0,0,0,2'd0,0,2'd0,3'd0,0,0,0,1,0);
        cHB = mk(0,0,0,0,0,2'd0,0,2'd0,3'd0,0,0,0,1,1);
        cJL = mk(0,0,0,0,1,2'd2,0,2'd0,3'd0,1,0,0,0,0) | 19'd1;

        // Main program: reset, then one of each instruction class.
        add(0,6'h00,6'h00,0,1,cZ,0);   add(0,6'h00,6'h00,0,1,cZ,0);
        add(1,6'h00,6'h00,0,1,cZ,0);   add(1,6'h3F,6'h3F,0,1,cF1,0);
        add(1,6'h00,6'h21,0,1,cD,0);   add(1,6'h00,6'h21,0,1,cER,0);
        add(1,6'h00,6'h21,0,1,cWR,0);  add(1,6'h3F,6'h3F,0,1,cF1,1);
        add(1,6'h00,6'h23,0,1,cD,1);   add(1,6'h00,6'h23,0,1,cER,1);
        add(1,6'h00,6'h23,0,1,cWR,1);  add(1,6'h3F,6'h3F,0,1,cF1,2);
        add(1,6'h0D,6'h00,0,1,cD,2);   add(1,6'h0D,6'h00,0,1,cEO,2);
        add(1,6'h0D,6'h00,0,1,cWI,2);  add(1,6'h3F,6'h3F,0,1,cF1,3);
        add(1,6'h0F,6'h00,0,1,cD,3);   add(1,6'h0F,6'h00,0,1,cEL,3);
        add(1,6'h0F,6'h00,0,1,cWI,3);  add(1,6'h3F,6'h3F,0,1,cF1,4);
        add(1,6'h23,6'h00,0,1,cD,4);   add(1,6'h23,6'h00,0,1,cEM,4);
        add(1,6'h23,6'h00,0,0,cML,4);  add(1,6'h23,6'h00,0,0,cML,4);
        add(1,6'h23,6'h00,0,0,cML,4);  add(1,6'h23,6'h00,0,1,cML,4);
        add(1,6'h23,6'h00,0,1,cWL,4);  add(1,6'h3F,6'h3F,0,1,cF1,5);
        add(1,6'h2B,6'h00,0,1,cD,5);   add(1,6'h2B,6'h00,0,1,cEM,5);
        add(1,6'h2B,6'h00,0,1,cMS,5);  add(1,6'h3F,6'h3F,0,1,cF1,6);
        add(1,6'h04,6'h00,1,1,cD,6);   add(1,6'h04,6'h00,1,1,cB1,6);
        add(1,6'h3F,6'h3F,0,1,cF1,7);  add(1,6'h04,6'h00,0,1,cD,7);
        add(1,6'h04,6'h00,0,1,cB0,7);  add(1,6'h3F,6'h3F,0,1,cF1,8);
        add(1,6'h02,6'h00,0,1,cD,8);   add(1,6'h02,6'h00,0,1,cJ,8);
        add(1,6'h3F,6'h3F,0,0,cF0,9);  add(1,6'h3F,6'h3F,0,0,cF0,9);
        add(1,6'h3F,6'h3F,0,1,cF1,9);  add(1,6'h02,6'h00,0,1,cD,9);
        add(1,6'h02,6'h00,0,1,cJ,9);   add(1,6'h3F,6'h3F,0,1,cF1,10);
        add(1,6'h00,6'h20,0,1,cD,10);  add(1,6'h00,6'h20,0,1,cH,10);
        add(1,6'h00,6'h20,0,1,cH,10);
        run("prog");

        // Illegal opcode after one retired addu: HALT absorbs, no memory traffic, count frozen.
        add(0,6'h00,6'h00,0,1,cZ,0);   add(1,6'h00,6'h00,0,1,cZ,0);
        add(1,6'h00,6'h21,0,1,cF1,0);  add(1,6'h00,6'h21,0,1,cD,0);
        add(1,6'h00,6'h21,0,1,cER,0);  add(1,6'h00,6'h21,0,1,cWR,0);
        add(1,6'h3F,6'h3F,0,1,cF1,1);  add(1,6'h3F,6'h3F,0,1,cD,1);
        for (int i = 0; i < 20; i++) add(1,6'h3F,6'h3F,0,1,cH,1);
        run("halt");

        // jal: legal only when the optional link feature is built in.
        add(0,6'h00,6'h00,0,1,cZ,0);   add(1,6'h00,6'h00,0,1,cZ,0);
        add(1,6'h03,6'h00,0,1,cF1,0);  add(1,6'h03,6'h00,0,1,cD,0);
`ifdef MC_CTRL_JAL_EN
        add(1,6'h03,6'h00,0,1,cJL,0);  add(1,6'h3F,6'h3F,0,1,cF1,1);
`else
        add(1,6'h03,6'h00,0,1,cH,0);   add(1,6'h03,6'h00,0,1,cH,0);
`endif
        run("jal");

        // Fetch timeout: four missed cycles fault; reset clears the sticky flag.
        add(0,6'h00,6'h00,0,0,cZ,0);   add(1,6'h00,6'h00,0,0,cZ,0);
        for (int i = 0; i < 4; i++) add(1,6'h00,6'h00,0,0,cF0,0);
        add(1,6'h00,6'h00,0,0,cHB,0);  add(1,6'h00,6'h00,0,1,cHB,0);
        add(0,6'h00,6'h00,0,1,cZ,0);
        run("fetch_tmo");

        // Memory-access timeout on a store.
        add(0,6'h00,6'h00,0,1,cZ,0);   add(1,6'h00,6'h00,0,1,cZ,0);
        add(1,6'h2B,6'h00,0,1,cF1,0);  add(1,6'h2B,6'h00,0,1,cD,0);
        add(1,6'h2B,6'h00,0,1,cEM,0);
        for (int i = 0; i < 4; i++) add(1,6'h2B,6'h00,0,0,cMS,0);
        add(1,6'h2B,6'h00,0,0,cHB,0);
        run("mem_tmo");

        // Reset asserted in the middle of a stalled load: request drops without a clock edge.
        add(0,6'h00,6'h00,0,1,cZ,0);   add(1,6'h00,6'h00,0,1,cZ,0);
        add(1,6'h23,6'h00,0,1,cF1,0);  add(1,6'h23,6'h00,0,1,cD,0);
        add(1,6'h23,6'h00,0,1,cEM,0);  add(1,6'h23,6'h00,0,0,cML,0);
        run("mid_rst");
        #2 rst = 1'b0;
        #1;
        check("mid_rst.mem_req", 0, 32'(a_ctl[18]), 32'd0);
        check("mid_rst.bus_fault", 0, 32'(a_ctl[1]), 32'd0);
        check("mid_rst.ctl", 0, 32'(a_ctl), 32'(cZ));
        add(1,6'h00,6'h00,0,1,cZ,0);   add(1,6'h3F,6'h3F,0,1,cF1,0);
        run("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
